// File: rtl/ps2_tx_if.sv
// Command/status handshake between a host controller and the PS/2 transmitter.
interface ps2_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err;

  modport master (output wr_ps2, output din,
                  input tx_idle, input tx_done_tick, input tx_err);
  modport slave  (input wr_ps2, input din,
                  output tx_idle, output tx_done_tick, output tx_err);
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits, odd parity, stop, then ack check.
// state | meaning
// IDLE  | pins released, waiting for wr_ps2
// RTS   | ps2c held low for RTS_CYCLES
// START | ps2c released, start bit (0) on ps2d
// DATA  | d0..d7 then parity shifted out on device falling edges
// STOP  | ps2d released as stop bit
// ACK   | waiting for the device to pull ps2d low on the final edge
module ps2_tx #(
  parameter int RTS_CYCLES     = 8191,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic     clk_i,
  input  logic     reset_i,
  ps2_tx_if.slave  bus,
  inout  wire      ps2c_io,
  inout  wire      ps2d_io
);

  typedef enum logic [2:0] {
    S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_ACK
  } state_t;

  localparam logic [19:0] RTS_LOAD = 20'(RTS_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  filt_q, filt_d;
  logic        f_ps2c_q, f_ps2c_d;
  logic [8:0]  b_q;
  logic [3:0]  n_q;
  logic [19:0] t_q;
  logic        err_q;
  logic        fall_edge, watchdog, timeout, c_en, d_low;

  always_comb begin
    filt_d   = {ps2c_io, filt_q[7:1]};
    f_ps2c_d = f_ps2c_q;
    if (&filt_d)
      f_ps2c_d = 1'b1;
    else if (~|filt_d)
      f_ps2c_d = 1'b0;
  end

  assign fall_edge = f_ps2c_q & ~f_ps2c_d;
  assign watchdog  = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_STOP)  || (state_q == S_ACK);
  // A real edge takes priority over a coincident timeout.
  assign timeout   = watchdog && !fall_edge && (t_q == TO_LAST);

  assign c_en  = (state_q == S_RTS);
  assign d_low = (state_q == S_START) || ((state_q == S_DATA) && !b_q[0]);

  assign ps2c_io = c_en  ? 1'b0 : 1'bz;
  assign ps2d_io = d_low ? 1'b0 : 1'bz;

  assign bus.tx_idle      = (state_q == S_IDLE);
  assign bus.tx_done_tick = ((state_q == S_ACK) && fall_edge) || timeout;
  assign bus.tx_err       = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      filt_q   <= '0;
      f_ps2c_q <= 1'b0;
      b_q      <= '0;
      n_q      <= '0;
      t_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      f_ps2c_q <= f_ps2c_d;
      case (state_q)
        S_IDLE: begin
          if (bus.wr_ps2) begin
            b_q     <= {~^bus.din, bus.din};
            t_q     <= RTS_LOAD;
            state_q <= S_RTS;
          end
        end
        S_RTS: begin
          if (t_q == 20'd0)
            state_q <= S_START;
          else
            t_q <= t_q - 20'd1;
        end
        default: begin
          if (timeout) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            t_q <= fall_edge ? 20'd0 : t_q + 20'd1;
            if (fall_edge) begin
              case (state_q)
                S_START: begin
                  n_q     <= 4'd8;
                  state_q <= S_DATA;
                end
                S_DATA: begin
                  b_q <= {1'b0, b_q[8:1]};
                  if (n_q == 4'd0)
                    state_q <= S_STOP;
                  else
                    n_q <= n_q - 4'd1;
                end
                S_STOP:  state_q <= S_ACK;
                S_ACK: begin
                  err_q   <= ps2d_io;
                  state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
